// File: rtl/mem_read_port_pkg.sv
// Shared definitions for the buffered memory read port.
//   RSP_DEPTH_DEF : default number of response FIFO entries
//   RSP_CNT_W     : count width for the default FIFO depth
//   count_width() : bits needed to hold an occupancy of 0..depth
//   ptr_inc()     : circular pointer increment for any (non power-of-two) depth
package mem_read_port_pkg;

  localparam int unsigned RSP_DEPTH_DEF = 3;
  localparam int unsigned RSP_CNT_W     = $clog2(RSP_DEPTH_DEF + 1);

  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Wraps to 0 after depth-1, so the FIFO depth need not be a power of two.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr + 1 >= depth) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/mem_read_port_if.sv
// Bus bundle for mem_read_port: masked write port, read request channel and
// read response channel.
//   master : drives writes, requests and response-ready (the consumer side)
//   slave  : the memory block itself
interface mem_read_port_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 2
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic [WIDTH-1:0]  wr_mask;
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rd_req_addr;
  logic              rd_rsp_valid;
  logic              rd_rsp_ready;
  logic [WIDTH-1:0]  rd_rsp_data;
  logic              rd_busy;

  modport master (
    output wr_en, wr_addr, wr_data, wr_mask,
    output rd_req_valid, rd_req_addr, rd_rsp_ready,
    input  rd_req_ready, rd_rsp_valid, rd_rsp_data, rd_busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_mask,
    input  rd_req_valid, rd_req_addr, rd_rsp_ready,
    output rd_req_ready, rd_rsp_valid, rd_rsp_data, rd_busy
  );
endinterface

// File: rtl/mem_read_port_fifo.sv
// Synchronous circular-buffer FIFO holding read responses.
//   clk, rst   : clock, asynchronous active-low reset (pointers/count/head)
//   push/push_data : write one entry at the tail
//   pop        : remove the head entry (only while valid)
//   count      : current occupancy 0..RSP_DEPTH
//   valid/data : head entry present / registered copy of the head entry
module mem_read_port_fifo
  import mem_read_port_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned RSP_DEPTH = RSP_DEPTH_DEF,
  localparam int unsigned CNT_W    = count_width(RSP_DEPTH),
  localparam int unsigned PTR_W    = $clog2(RSP_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] store_q [RSP_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, rd_ptr_inc;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    rd_ptr_inc = PTR_W'(ptr_inc(32'(rd_ptr_q), RSP_DEPTH));
    wr_ptr_d   = push ? PTR_W'(ptr_inc(32'(wr_ptr_q), RSP_DEPTH)) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_inc : rd_ptr_q;
    count_d    = count_q;
    head_d     = head_q;

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // The head register tracks whatever entry will sit at the read pointer
    // next cycle; when the FIFO drains it simply holds its last value.
    if (pop) begin
      if (count_q > CNT_W'(1))  head_d = store_q[rd_ptr_inc];
      else if (push)            head_d = push_data;
    end else if (count_q == '0 && push) begin
      head_d = push_data;
    end
  end

  // NOTE: storage is deliberately not reset; only pointers, count and head need a known state.
  always_ff @(posedge clk) begin
    if (push) store_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign count = count_q;
  assign valid = (count_q != '0);
  assign data  = head_q;

  // The upstream acceptance rule must never let a push land on a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && count_q == CNT_W'(RSP_DEPTH)));

endmodule

// File: rtl/mem_read_port.sv
// DEPTH x WIDTH memory with a masked registered write port and a buffered
// valid/ready read port.
//   clk, rst : clock, asynchronous active-low reset (read path only)
//   bus      : mem_read_port_if.slave -- wr_en/addr/data/mask write port,
//              rd_req_* request channel, rd_rsp_* response channel, rd_busy
// A read accepted in cycle T samples the array in T (read-before-write),
// is in flight during T+1 and enters the response FIFO at the end of T+1.
module mem_read_port
  import mem_read_port_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned RSP_DEPTH = RSP_DEPTH_DEF,
  localparam int unsigned ADDR_W   = $clog2(DEPTH),
  localparam int unsigned CNT_W    = count_width(RSP_DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  mem_read_port_if.slave bus
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] wr_word_d;
  logic             inflight_q, inflight_d;
  logic [WIDTH-1:0] rd_word_q, rd_word_d;
  logic             req_ready;
  logic             req_fire;
  logic             rsp_pop;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   occupancy;

  always_comb begin
    wr_word_d  = (mem_q[bus.wr_addr] & ~bus.wr_mask) | (bus.wr_data & bus.wr_mask);
    // Reserve a FIFO slot for the in-flight read so the push can never overflow;
    // only registered state feeds this, never rd_rsp_ready.
    occupancy  = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight_q);
    req_ready  = occupancy < (CNT_W+1)'(RSP_DEPTH);
    req_fire   = bus.rd_req_valid & req_ready;
    inflight_d = req_fire;
    rd_word_d  = req_fire ? mem_q[bus.rd_req_addr] : rd_word_q;
    rsp_pop    = rsp_valid & bus.rd_rsp_ready;
  end

  always_ff @(posedge clk) begin
    if (bus.wr_en) mem_q[bus.wr_addr] <= wr_word_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_q <= 1'b0;
      rd_word_q  <= '0;
    end else begin
      inflight_q <= inflight_d;
      rd_word_q  <= rd_word_d;
    end
  end

  mem_read_port_fifo #(
    .WIDTH     (WIDTH),
    .RSP_DEPTH (RSP_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (rd_word_q),
    .pop       (rsp_pop),
    .count     (fifo_count),
    .valid     (rsp_valid),
    .data      (rsp_data)
  );

  assign bus.rd_req_ready = req_ready;
  assign bus.rd_rsp_valid = rsp_valid;
  assign bus.rd_rsp_data  = rsp_data;
  assign bus.rd_busy      = inflight_q | (fifo_count != '0);

endmodule
